score_accumulator: RTL and testbench
====================================

// Module: score_accumulator
// PURPOSE
//  Game-score keeper for the rhythm game. Collects per-lane hit judgements from the note
//  judge and maintains total_Score, which feeds curr_score_ten / curr_score_one.
//  Also tracks the current combo and the best combo, and runs the IDLE/PLAY/DONE game phases.
//  Runs on frame_clk. All outputs are registered.
// PARAMETERS
//  MAX_SCORE     99  saturation ceiling for total_Score; keeps the digit renderers in 0..9
//  PERFECT_PTS   2   points per PERFECT judgement
//  GOOD_PTS      1   points per GOOD judgement
//  COMBO_THRESH  10  pre-cycle combo value at or above which each PERFECT earns +1 bonus
// PORTS
//  frame_clk      in   1  clock; one judgement cycle per frame
//  Reset          in   1  asynchronous reset, active-high
//  game_start     in   1  single-cycle pulse; clears the score and enters PLAY
//  game_end       in   1  single-cycle pulse; freezes the score and enters DONE
//  hit_valid      in   4  per-lane judgement strobe, lane i = bit i
//  hit_grade      in   8  per-lane grade, lane i = [2i+1:2i]; 00 MISS, 01 GOOD, 10 PERFECT, 11 ignored
//  total_Score    out  8  accumulated score, 0..MAX_SCORE
//  combo          out  8  current consecutive non-miss count, saturates at 255
//  max_combo      out  8  largest combo reached since the last game_start, saturates at 255
//  score_changed  out  1  one-cycle pulse when total_Score changed on this edge
//  playing        out  1  high in PLAY
//  done           out  1  high in DONE
// BEHAVIOUR
//  Reset (async): state=IDLE; total_Score, combo and max_combo = 0; score_changed, playing
//   and done = 0.
//  FSM:
//   IDLE -game_start-> PLAY
//   PLAY -game_end-> DONE
//   PLAY -game_start-> PLAY (restart)
//   DONE -game_start-> PLAY
//   Any other input leaves the state unchanged.
//  Entering or re-entering PLAY on game_start: total_Score, combo and max_combo <= 0 on the
//   same edge. Hits in that cycle are discarded.
//  Judgements are counted only when state==PLAY, game_start=0 and hit_valid[i]=1.
//   Hits are ignored in IDLE and DONE.
//  A lane with grade 11 is ignored entirely. It counts as neither a hit nor a miss.
//  Per-cycle increment:
//   inc = sum over lanes of {PERFECT_PTS + bonus, GOOD_PTS, 0 for MISS}
//   bonus = 1 for a PERFECT when the registered (pre-cycle) combo >= COMBO_THRESH, else 0
//   Maximum inc with defaults = 12. Compute in 9 bits.
//  total_Score <= min(total_Score + inc, MAX_SCORE). No wrap-around, ever.
//  Combo:
//   n = number of counted GOOD/PERFECT lanes this cycle
//   any counted MISS this cycle -> combo <= 0. A miss dominates hits in the same cycle.
//   otherwise combo <= min(combo + n, 255)
//  max_combo <= max(max_combo, new combo value).
//  game_end together with hits in PLAY: the hits are counted on that edge, then state=DONE.
//  score_changed: registered. It is 1 in the cycle after an edge where total_Score took a
//   new value, including a clear to 0 from a nonzero value. Otherwise 0.
//  Latency: a judgement appears on total_Score and combo one frame_clk edge after it is
//   presented.
//  Outputs hold their values in DONE until the next game_start or Reset.
//  Reset asserted mid-game: immediate return to the reset values. Post-reset state is IDLE.
//  playing = (state==PLAY); done = (state==DONE). Both are decoded from the state register.
// TESTING
//  T1 Reset, then game_start; 3 cycles of lane0 PERFECT -> total_Score=6, combo=3,
//   score_changed pulses 3 times.
//  T2 In PLAY, one cycle with lanes0-2 GOOD and lane3 MISS -> total_Score +=3, combo=0,
//   max_combo keeps its prior value.
//  T3 Build combo to 10, then a cycle with lanes0-3 all PERFECT -> inc=12, combo=14.
//   The bonus is applied to all four PERFECT lanes.
//  T4 total_Score=95, then 4xPERFECT -> total_Score=99 (saturated).
//   A further hit -> stays 99, score_changed=0.
//  T5 game_end in the same cycle as lane1 GOOD -> score counted, done=1.
//   Later hits are ignored; game_start clears all counters and sets playing=1.
//  T6 Assert Reset asynchronously between edges mid-game -> outputs are 0 before the next
//   edge. Hits in IDLE are ignored.

Source files
------------

// File: rtl/score_accumulator_if.sv
// Judge/game-control inputs and score outputs of the score accumulator.
interface score_accumulator_if;
  logic       game_start;
  logic       game_end;
  logic [3:0] hit_valid;
  logic [7:0] hit_grade;
  logic [7:0] total_Score;
  logic [7:0] combo;
  logic [7:0] max_combo;
  logic       score_changed;
  logic       playing;
  logic       done;

  modport master (
    output game_start, game_end, hit_valid, hit_grade,
    input  total_Score, combo, max_combo, score_changed, playing, done
  );

  modport slave (
    input  game_start, game_end, hit_valid, hit_grade,
    output total_Score, combo, max_combo, score_changed, playing, done
  );
endinterface

// File: rtl/score_accumulator.sv
// Rhythm-game score keeper: accumulates per-lane judgements into a saturating score,
// tracks current/best combo and sequences the IDLE/PLAY/DONE game phases.
module score_accumulator #(
  parameter int unsigned MAX_SCORE    = 99,
  parameter int unsigned PERFECT_PTS  = 2,
  parameter int unsigned GOOD_PTS     = 1,
  parameter int unsigned COMBO_THRESH = 10
) (
  input logic                 frame_clk,
  input logic                 Reset,
  score_accumulator_if.slave  bus
);

  localparam int unsigned SW = 8;
  localparam int unsigned IW = 9;
  localparam int unsigned NL = 4;
  localparam int unsigned CW = 3;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PLAY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [1:0] G_MISS = 2'b00;
  localparam logic [1:0] G_GOOD = 2'b01;
  localparam logic [1:0] G_PERF = 2'b10;

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] score_q, score_d;
  logic [SW-1:0] combo_q, combo_d;
  logic [SW-1:0] max_q, max_d;
  logic          changed_q;

  logic          count_en;
  logic          bonus;
  logic [IW-1:0] inc;
  logic [IW-1:0] score_sum;
  logic [IW-1:0] combo_sum;
  logic [CW-1:0] n_hits;
  logic          any_miss;
  logic [1:0]    grade;

  // Game phase transitions; game_start takes priority over game_end.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.game_start) state_d = PLAY;
      PLAY:    if (bus.game_start) state_d = PLAY;
               else if (bus.game_end) state_d = DONE;
      DONE:    if (bus.game_start) state_d = PLAY;
      default: state_d = IDLE;
    endcase
  end

  // Bonus decision uses the combo held before this cycle's judgements.
  assign count_en = (state_q == PLAY) && !bus.game_start;
  assign bonus    = (combo_q >= SW'(COMBO_THRESH));

  always_comb begin
    inc      = '0;
    n_hits   = '0;
    any_miss = 1'b0;
    grade    = G_MISS;
    for (int i = 0; i < int'(NL); i++) begin
      grade = bus.hit_grade[2*i +: 2];
      if (count_en && bus.hit_valid[i]) begin
        case (grade)
          G_PERF: begin
            inc    = inc + IW'(PERFECT_PTS) + (bonus ? IW'(1) : IW'(0));
            n_hits = n_hits + CW'(1);
          end
          G_GOOD: begin
            inc    = inc + IW'(GOOD_PTS);
            n_hits = n_hits + CW'(1);
          end
          G_MISS:  any_miss = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Next score/combo values; a miss anywhere in the cycle breaks the combo.
  always_comb begin
    score_sum = IW'(score_q) + inc;
    combo_sum = IW'(combo_q) + IW'(n_hits);
    score_d   = (score_sum > IW'(MAX_SCORE)) ? SW'(MAX_SCORE) : score_sum[SW-1:0];
    if (any_miss)
      combo_d = '0;
    else if (combo_sum > IW'(255))
      combo_d = SW'(255);
    else
      combo_d = combo_sum[SW-1:0];
    max_d = (combo_d > max_q) ? combo_d : max_q;
    if (bus.game_start) begin
      score_d = '0;
      combo_d = '0;
      max_d   = '0;
    end else if (!count_en) begin
      score_d = score_q;
      combo_d = combo_q;
      max_d   = max_q;
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      score_q   <= '0;
      combo_q   <= '0;
      max_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      score_q   <= score_d;
      combo_q   <= combo_d;
      max_q     <= max_d;
      changed_q <= (score_d != score_q);
    end
  end

  assign bus.total_Score   = score_q;
  assign bus.combo         = combo_q;
  assign bus.max_combo     = max_q;
  assign bus.score_changed = changed_q;
  assign bus.playing       = (state_q == PLAY);
  assign bus.done          = (state_q == DONE);

endmodule

// File: tb/tb_score_accumulator.sv
// Scoreboard bench for score_accumulator: directed judgement vectors, expected
// results queued at issue time and compared by an independent monitor.
module tb_score_accumulator;

  typedef struct packed {
    logic [7:0] score;
    logic [7:0] combo;
    logic [7:0] maxc;
    logic       chg;
    logic       play;
    logic       dn;
  } exp_t;

  logic frame_clk = 1'b0;
  logic Reset     = 1'b1;
  int   checks    = 0;
  int   failures  = 0;

  exp_t  exp_q[$];
  string name_q[$];

  score_accumulator_if ifc ();

  score_accumulator dut (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .bus       (ifc.slave)
  );

  always #5 frame_clk = ~frame_clk;

  function automatic exp_t sample();
    exp_t a;
    a.score = ifc.total_Score;
    a.combo = ifc.combo;
    a.maxc  = ifc.max_combo;
    a.chg   = ifc.score_changed;
    a.play  = ifc.playing;
    a.dn    = ifc.done;
    return a;
  endfunction

  task automatic check(input string nm, input exp_t e);
    exp_t a;
    a = sample();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got score=%0d combo=%0d max=%0d chg=%0b play=%0b done=%0b, want score=%0d combo=%0d max=%0d chg=%0b play=%0b done=%0b",
               nm, a.score, a.combo, a.maxc, a.chg, a.play, a.dn,
               e.score, e.combo, e.maxc, e.chg, e.play, e.dn);
    end
  endtask

  // Drive one frame of inputs and queue the outputs expected after the next edge.
  task automatic step(input string nm, input logic st, input logic en,
                      input logic [3:0] v, input logic [7:0] g,
                      input logic [7:0] es, input logic [7:0] ec, input logic [7:0] em,
                      input logic ech, input logic ep, input logic ed);
    @(negedge frame_clk);
    ifc.game_start = st;
    ifc.game_end   = en;
    ifc.hit_valid  = v;
    ifc.hit_grade  = g;
    exp_q.push_back('{es, ec, em, ech, ep, ed});
    name_q.push_back(nm);
  endtask

  // Monitor: every edge that has a pending expectation gets compared.
  initial begin
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) check(name_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    ifc.game_start = 1'b0;
    ifc.game_end   = 1'b0;
    ifc.hit_valid  = 4'h0;
    ifc.hit_grade  = 8'h00;
    repeat (2) @(negedge frame_clk);
    check("reset_state", '{8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    Reset = 1'b0;

    // T1: start and three single-lane PERFECTs
    step("t1_start",  1, 0, 4'b0000, 8'h00,        0, 0, 0, 0, 1, 0);
    step("t1_perf1",  0, 0, 4'b0001, 8'b00000010,  2, 1, 1, 1, 1, 0);
    step("t1_perf2",  0, 0, 4'b0001, 8'b00000010,  4, 2, 2, 1, 1, 0);
    step("t1_perf3",  0, 0, 4'b0001, 8'b00000010,  6, 3, 3, 1, 1, 0);
    // T2: three GOODs with a MISS break the combo
    step("t2_miss",   0, 0, 4'b1111, 8'b00010101,  9, 0, 3, 1, 1, 0);
    // T3: combo build, threshold edge, bonus on all four PERFECTs
    step("t3_good4a", 0, 0, 4'b1111, 8'b01010101, 13, 4, 4, 1, 1, 0);
    step("t3_good4b", 0, 0, 4'b1111, 8'b01010101, 17, 8, 8, 1, 1, 0);
    step("t3_good1",  0, 0, 4'b0001, 8'b00000001, 18, 9, 9, 1, 1, 0);
    step("t3_nobonus",0, 0, 4'b0001, 8'b00000010, 20, 10, 10, 1, 1, 0);
    step("t3_bonus4", 0, 0, 4'b1111, 8'b10101010, 32, 14, 14, 1, 1, 0);
    step("t3_grade11",0, 0, 4'b1111, 8'b11111101, 33, 15, 15, 1, 1, 0);
    step("t3_novalid",0, 0, 4'b0000, 8'b10101010, 33, 15, 15, 0, 1, 0);
    // T4: climb to 95 then saturate at 99
    step("t4_p4a",    0, 0, 4'b1111, 8'b10101010, 45, 19, 19, 1, 1, 0);
    step("t4_p4b",    0, 0, 4'b1111, 8'b10101010, 57, 23, 23, 1, 1, 0);
    step("t4_p4c",    0, 0, 4'b1111, 8'b10101010, 69, 27, 27, 1, 1, 0);
    step("t4_p4d",    0, 0, 4'b1111, 8'b10101010, 81, 31, 31, 1, 1, 0);
    step("t4_p4e",    0, 0, 4'b1111, 8'b10101010, 93, 35, 35, 1, 1, 0);
    step("t4_g94",    0, 0, 4'b0001, 8'b00000001, 94, 36, 36, 1, 1, 0);
    step("t4_g95",    0, 0, 4'b0001, 8'b00000001, 95, 37, 37, 1, 1, 0);
    step("t4_sat",    0, 0, 4'b1111, 8'b10101010, 99, 41, 41, 1, 1, 0);
    step("t4_hold99", 0, 0, 4'b0001, 8'b00000010, 99, 42, 42, 0, 1, 0);
    step("t4_miss",   0, 0, 4'b0001, 8'b00000000, 99, 0, 42, 0, 1, 0);
    // T5: restart discards hits, game_end counts its own hits, DONE holds
    step("t5_restart",1, 0, 4'b1111, 8'b10101010,  0, 0, 0, 1, 1, 0);
    step("t5_perf",   0, 0, 4'b0001, 8'b00000010,  2, 1, 1, 1, 1, 0);
    step("t5_end_hit",0, 1, 4'b0010, 8'b00000100,  3, 2, 2, 1, 0, 1);
    step("t5_done_hit",0,0, 4'b1111, 8'b10101010,  3, 2, 2, 0, 0, 1);
    step("t5_done_end",0,1, 4'b0000, 8'h00,        3, 2, 2, 0, 0, 1);
    step("t5_start",  1, 0, 4'b0000, 8'h00,        0, 0, 0, 1, 1, 0);
    step("t5_lane2",  0, 0, 4'b0100, 8'b00100000,  2, 1, 1, 1, 1, 0);

    // T6: asynchronous reset between edges
    @(posedge frame_clk);
    #3;
    Reset = 1'b1;
    ifc.hit_valid = 4'h0;
    ifc.hit_grade = 8'h00;
    #1;
    check("t6_async_rst", '{8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0});
    @(negedge frame_clk);
    Reset = 1'b0;
    step("t6_idle_hit", 0, 0, 4'b0001, 8'b00000010, 0, 0, 0, 0, 0, 0);
    step("t6_idle_end", 0, 1, 4'b0000, 8'h00,       0, 0, 0, 0, 0, 0);
    step("t6_start",    1, 0, 4'b0000, 8'h00,       0, 0, 0, 0, 1, 0);
    step("t6_idle_fin", 0, 0, 4'b0000, 8'h00,       0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge frame_clk);
    #2;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
